mux2_stream_arb: RTL and testbench
==================================

MUX2_STREAM_ARB -- requirements
Module: mux2_stream_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width of both inputs and the output.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port areset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port a_valid, input, 1 bit: channel A offers data.
REQ-005 The block SHALL have port a_data, input, WIDTH bits: channel A payload.
REQ-006 The block SHALL have port a_ready, output, 1 bit: channel A transfer accepted this cycle.
REQ-007 The block SHALL have port b_valid, input, 1 bit: channel B offers data.
REQ-008 The block SHALL have port b_data, input, WIDTH bits: channel B payload.
REQ-009 The block SHALL have port b_ready, output, 1 bit: channel B transfer accepted this cycle.
REQ-010 The block SHALL have port sel, output, 1 bit: registered source of held data (0=A, 1=B); it drives the downstream 2:1 byte mux select.
REQ-011 The block SHALL have port out_valid, output, 1 bit: output slot holds data.
REQ-012 The block SHALL have port out_data, output, WIDTH bits: held payload.
REQ-013 The block SHALL have port out_ready, input, 1 bit: consumer accepts the output this cycle.

Function
REQ-014 A transfer SHALL occur on any channel when valid && ready are both high at a rising clk edge.
REQ-015 The output slot SHALL be a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 The slot SHALL be able to accept data when in EMPTY, or when in FULL with out_ready=1 (same-cycle drain and refill).
REQ-017 When only one input is valid and the slot can accept, that channel SHALL be granted.
REQ-018 When both inputs are valid and the slot can accept, the channel not granted most recently SHALL be granted (round-robin).
REQ-019 a_ready and b_ready SHALL be combinational; at most one SHALL be high in any cycle, and neither SHALL be high when the slot cannot accept.
REQ-020 The last-grant pointer SHALL update only on an actual input transfer; cycles without a grant SHALL leave it unchanged.
REQ-021 On a grant, out_data SHALL load the granted payload and sel SHALL load the granted channel at the same edge; latency from input transfer to out_valid SHALL be 1 cycle.
REQ-022 While FULL and out_ready=0, out_data and sel SHALL hold stable.
REQ-023 Transitions: EMPTY->FULL on grant; FULL->EMPTY on out_ready with no grant; FULL->FULL on out_ready with grant, or on no out_ready.
REQ-024 Sustained throughput SHALL be one transfer per cycle when out_ready is held at 1.
REQ-025 Input data SHALL pass through unmodified; no width conversion is applied.

Reset
REQ-026 While areset=1, out_valid=0, out_data=0, sel=0, FSM=EMPTY, and the last-grant pointer=B, so that A wins the first contention.
REQ-027 An assertion of areset mid-transfer SHALL discard held data immediately, without waiting for a clock edge.
REQ-028 a_ready and b_ready SHALL be 0 during reset.

Structure
REQ-029 Package mux2_arb_pkg SHALL hold typedef chan_e (CH_A=0, CH_B=1) and typedef slot_state_e (EMPTY, FULL).
REQ-030 The one-entry output register and its FSM SHALL be a sub-module named mux2_arb_slot; grant logic SHALL stay in the top.

Verification
REQ-031 Reset then idle: assert areset mid-run with the slot FULL -> out_valid=0, sel=0 without a clk edge; after release, a_ready=b_ready=0 until a valid input arrives.
REQ-032 Single channel: a_valid=1, a_data=0x3C, out_ready=1 -> next cycle out_valid=1, out_data=0x3C, sel=0.
REQ-033 Contention: A=0x11, B=0x22 held valid, out_ready=1 for 4 cycles -> outputs 0x11,0x22,0x11,0x22 with sel 0,1,0,1.
REQ-034 Backpressure: slot FULL with 0x55 from B and out_ready=0 for 3 cycles -> a_ready=b_ready=0; out_data=0x55 and sel=1 stable throughout.
REQ-035 Drain and refill: FULL with out_ready=1 and b_valid=1, b_data=0xAA -> b_ready=1 in the same cycle; next cycle out_valid=1, out_data=0xAA, with no bubble.
REQ-036 Pointer hold: grant A, then 2 idle cycles, then A and B both valid -> B is granted first.

Source files
------------

// File: rtl/mux2_arb_pkg.sv
// mux2_arb_pkg: shared channel and slot-state types for the 2:1 stream arbiter
package mux2_arb_pkg;
  typedef enum logic {CH_A = 1'b0, CH_B = 1'b1} chan_e;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_e;
endpackage

// File: rtl/mux2_arb_slot.sv
// mux2_arb_slot: one-entry output register holding payload and source select
import mux2_arb_pkg::*;
module mux2_arb_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             i_load,
  input  logic             i_chan,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_out_ready,
  output logic             o_can_accept,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_sel
);
  slot_state_e      r_state;
  slot_state_e      w_next;
  logic [WIDTH-1:0] r_data;
  logic             r_sel;
  always_comb begin
    w_next = i_load ? FULL : (r_state == FULL && !i_out_ready) ? FULL : EMPTY;
  end
  always_ff @(posedge clk or posedge areset) begin
    if (areset) r_state <= EMPTY;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_data <= '0;
      r_sel  <= 1'b0;
    end else if (i_load) begin
      r_data <= i_data;
      r_sel  <= i_chan;
    end
  end
  assign o_can_accept = (r_state == EMPTY) || i_out_ready;
  assign o_valid      = (r_state == FULL);
  assign o_data       = r_data;
  assign o_sel        = r_sel;
endmodule

// File: rtl/mux2_stream_arb.sv
// mux2_stream_arb: round-robin 2:1 stream arbiter feeding a one-entry output slot
import mux2_arb_pkg::*;
module mux2_stream_arb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);
  chan_e r_last;
  chan_e w_chan;
  logic  w_can_accept;
  logic  w_ok;
  logic  w_pick_b;
  logic  w_load;
  always_comb begin
    w_ok     = w_can_accept && !areset;
    w_pick_b = b_valid && (!a_valid || r_last == CH_A);
    a_ready  = w_ok && a_valid && !w_pick_b;
    b_ready  = w_ok && w_pick_b;
    w_load   = a_ready || b_ready;
    w_chan   = b_ready ? CH_B : CH_A;
  end
  // Starts at B so A wins the first contention after reset.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) r_last <= CH_B;
    else if (w_load) r_last <= w_chan;
  end
  mux2_arb_slot #(.WIDTH(WIDTH)) u_slot (
    .clk          (clk),
    .areset       (areset),
    .i_load       (w_load),
    .i_chan       (w_chan),
    .i_data       (b_ready ? b_data : a_data),
    .i_out_ready  (out_ready),
    .o_can_accept (w_can_accept),
    .o_valid      (out_valid),
    .o_data       (out_data),
    .o_sel        (sel)
  );
endmodule

// File: tb/tb_mux2_stream_arb.sv
// tb_mux2_stream_arb: directed self-checking bench for mux2_stream_arb
module tb_mux2_stream_arb;
  logic       clk = 1'b0;
  logic       areset;
  logic       a_valid, b_valid, a_ready, b_ready;
  logic [7:0] a_data, b_data, out_data;
  logic       sel, out_valid, out_ready;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_data [4] = '{8'h11, 8'h22, 8'h11, 8'h22};
  logic       exp_sel [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  mux2_stream_arb #(.WIDTH(8)) dut (
    .clk       (clk),
    .areset    (areset),
    .a_valid   (a_valid),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    areset = 1'b1; a_valid = 1'b1; a_data = 8'h00; b_valid = 1'b0; b_data = 8'h00; out_ready = 1'b0;
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b want 0", out_valid); end
    n_checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b%b want 00", a_ready, b_ready); end
    n_checks++; if (out_data !== 8'h00 || sel !== 1'b0) begin n_fail++; $display("FAIL rst_data got %h/%b want 00/0", out_data, sel); end
    a_valid = 1'b0;
    #2 areset = 1'b0;
    b_valid = 1'b1; b_data = 8'h99;
    step();
    b_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || sel !== 1'b1 || out_data !== 8'h99) begin n_fail++; $display("FAIL pre_async got %b/%b/%h want 1/1/99", out_valid, sel, out_data); end
    #2 areset = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0 || sel !== 1'b0 || out_data !== 8'h00) begin n_fail++; $display("FAIL async_rst got %b/%b/%h want 0/0/00", out_valid, sel, out_data); end
    #1 areset = 1'b0;
    step();
    n_checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL idle got %b%b%b want 000", a_ready, b_ready, out_valid); end
  endtask
  task automatic test_contention();
    a_valid = 1'b1; a_data = 8'h11; b_valid = 1'b1; b_data = 8'h22; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++; if (out_valid !== 1'b1 || out_data !== exp_data[i] || sel !== exp_sel[i]) begin n_fail++; $display("FAIL contention[%0d] got %b/%h/%b want 1/%h/%b", i, out_valid, out_data, sel, exp_data[i], exp_sel[i]); end
    end
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL contention_drain got %b want 0", out_valid); end
  endtask
  task automatic test_single();
    a_valid = 1'b1; a_data = 8'h3C; out_ready = 1'b1;
    #1;
    n_checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready got %b%b want 10", a_ready, b_ready); end
    step();
    a_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h3C || sel !== 1'b0) begin n_fail++; $display("FAIL single got %b/%h/%b want 1/3c/0", out_valid, out_data, sel); end
    step();
  endtask
  task automatic test_backpressure();
    b_valid = 1'b1; b_data = 8'h55; out_ready = 1'b1;
    step();
    a_valid = 1'b1; a_data = 8'h66; b_data = 8'h77; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d] got %b%b want 00", i, a_ready, b_ready); end
      step();
      n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h55 || sel !== 1'b1) begin n_fail++; $display("FAIL bp_hold[%0d] got %b/%h/%b want 1/55/1", i, out_valid, out_data, sel); end
    end
    a_valid = 1'b0; b_valid = 1'b0;
  endtask
  task automatic test_drain_refill();
    b_valid = 1'b1; b_data = 8'hAA; out_ready = 1'b1;
    #1;
    n_checks++; if (b_ready !== 1'b1 || a_ready !== 1'b0) begin n_fail++; $display("FAIL refill_ready got %b%b want 01", a_ready, b_ready); end
    step();
    b_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'hAA || sel !== 1'b1) begin n_fail++; $display("FAIL refill got %b/%h/%b want 1/aa/1", out_valid, out_data, sel); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL refill_drain got %b want 0", out_valid); end
  endtask
  task automatic test_pointer_hold();
    a_valid = 1'b1; a_data = 8'h01; out_ready = 1'b1;
    step();
    a_valid = 1'b0;
    step();
    step();
    a_valid = 1'b1; a_data = 8'h02; b_valid = 1'b1; b_data = 8'h03;
    #1;
    n_checks++; if (b_ready !== 1'b1 || a_ready !== 1'b0) begin n_fail++; $display("FAIL ptr_ready got %b%b want 01", a_ready, b_ready); end
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 8'h03 || sel !== 1'b1) begin n_fail++; $display("FAIL ptr_grant got %b/%h/%b want 1/03/1", out_valid, out_data, sel); end
  endtask
  initial begin
    test_reset();
    test_contention();
    test_single();
    test_backpressure();
    test_drain_refill();
    test_pointer_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
